// File: rtl/frame_tx_reader.sv
// frame_tx_reader: drains frames from the bridge byte FIFO toward the TX MAC.
// A small descriptor queue holds frame lengths; each frame is read from the
// FIFO's registered read port through a 2-entry skid buffer and presented as
// a valid/ready byte stream with tx_last, followed by an inter-frame gap.
// Optional feature macro: FRAME_TX_PAD_EN (pads short frames to MIN_LEN with 0x00).
module frame_tx_reader #(
  parameter int LEN_DEPTH  = 4,   // power of two, at least 2
  parameter int IFG_CYCLES = 12,  // at least 1
  parameter int MIN_LEN    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] len_in,
  input  logic       len_valid,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  input  logic       tx_ready,
  output logic       busy,
  output logic       len_ovf,
  output logic       underrun
);

`ifdef FRAME_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int PW = $clog2(LEN_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, IFG} state_t;

  state_t        state_q;
  logic [7:0]    rd_left_q;
  logic [7:0]    tx_left_q;
  logic [GW-1:0] ifg_cnt_q;

  // Descriptor queue; the head is read combinationally so LOAD stays one cycle.
  logic [7:0]    q_mem [LEN_DEPTH];
  logic [PW-1:0] q_wr_q, q_rd_q;
  logic [CW-1:0] q_cnt_q;
  logic          q_pop, q_full, q_push_ok;
  logic [7:0]    head_len, tx_len;

  // Skid buffer and output register.
  logic [7:0] buf_q [2];
  logic       buf_wr_q, buf_rd_q;
  logic [1:0] occ_q;
  logic       inflight_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q, tx_last_q;
  logic       len_ovf_q, underrun_q, starve_q;

  logic       hs, slot_free, src_avail, pad_src, out_load, consume;
  logic       buf_push, buf_pop, starve;
  logic [7:0] eff_left, src_data;
  logic [2:0] occ_sum;

  assign q_pop     = (state_q == LOAD);
  assign q_full    = (q_cnt_q == CW'(LEN_DEPTH));
  assign q_push_ok = len_valid && (!q_full || q_pop);
  assign head_len  = q_mem[q_rd_q];
  assign tx_len    = (PAD_EN && (head_len < 8'(MIN_LEN))) ? 8'(MIN_LEN) : head_len;

  // tx_left counts unacknowledged bytes including the one held in the output
  // register; when loading during a handshake that held byte is retiring.
  assign hs        = tx_valid_q && tx_ready;
  assign slot_free = !tx_valid_q || tx_ready;
  assign eff_left  = tx_left_q - {7'd0, tx_valid_q};
  assign src_avail = (occ_q != 2'd0) || inflight_q;
  assign pad_src   = PAD_EN && (rd_left_q == 8'd0) && !src_avail;
  assign out_load  = (state_q == STREAM) && slot_free && (eff_left != 8'd0)
                     && (src_avail || pad_src);
  assign consume   = out_load && src_avail;
  // An arriving byte bypasses the buffer when the buffer is empty and the
  // output register takes it in the same cycle.
  assign buf_pop   = consume && (occ_q != 2'd0);
  assign buf_push  = inflight_q && !(consume && (occ_q == 2'd0));
  assign src_data  = !src_avail ? 8'h00 :
                     (occ_q != 2'd0) ? buf_q[buf_rd_q] : fifo_data;

  assign occ_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, consume};
  assign fifo_rd = (state_q == STREAM) && (rd_left_q != 8'd0) && !fifo_empty
                   && (occ_sum < 3'd2);
  assign starve  = (state_q == STREAM) && (rd_left_q != 8'd0) && (occ_q == 2'd0)
                   && !inflight_q && fifo_empty;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = (state_q != IDLE);
  assign len_ovf  = len_ovf_q;
  assign underrun = underrun_q;

  // Frame sequencing: pick up a descriptor, stream it, then hold the gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_left_q <= 8'd0;
      tx_left_q <= 8'd0;
      ifg_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (q_cnt_q != '0) state_q <= LOAD;
        end
        LOAD: begin
          rd_left_q <= head_len;
          tx_left_q <= tx_len;
          state_q   <= (head_len == 8'd0) ? IDLE : STREAM;
        end
        STREAM: begin
          if (fifo_rd) rd_left_q <= rd_left_q - 8'd1;
          if (hs)      tx_left_q <= tx_left_q - 8'd1;
          if (hs && tx_last_q) begin
            state_q   <= IFG;
            ifg_cnt_q <= GW'(IFG_CYCLES - 1);
          end
        end
        IFG: begin
          if (ifg_cnt_q == '0) state_q <= IDLE;
          else                 ifg_cnt_q <= ifg_cnt_q - GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Descriptor queue pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr_q    <= '0;
      q_rd_q    <= '0;
      q_cnt_q   <= '0;
      len_ovf_q <= 1'b0;
    end else begin
      len_ovf_q <= len_valid && !q_push_ok;
      if (q_push_ok) q_wr_q <= q_wr_q + PW'(1);
      if (q_pop)     q_rd_q <= q_rd_q + PW'(1);
      case ({q_push_ok, q_pop})
        2'b10:   q_cnt_q <= q_cnt_q + CW'(1);
        2'b01:   q_cnt_q <= q_cnt_q - CW'(1);
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

  // Descriptor storage, no reset needed.
  always_ff @(posedge clk) begin
    if (q_push_ok) q_mem[q_wr_q] <= len_in;
  end

  // Skid buffer storage, no reset needed.
  always_ff @(posedge clk) begin
    if (buf_push) buf_q[buf_wr_q] <= fifo_data;
  end

  // Read tracking, buffer bookkeeping, output register and underrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf_wr_q   <= 1'b0;
      buf_rd_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      starve_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      inflight_q <= fifo_rd;
      if (buf_push) buf_wr_q <= ~buf_wr_q;
      if (buf_pop)  buf_rd_q <= ~buf_rd_q;
      case ({buf_push, buf_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (out_load) begin
        tx_data_q  <= src_data;
        tx_valid_q <= 1'b1;
        tx_last_q  <= (eff_left == 8'd1);
      end else if (hs) begin
        tx_valid_q <= 1'b0;
        tx_last_q  <= 1'b0;
      end
      starve_q   <= starve;
      underrun_q <= starve && !starve_q;
    end
  end

endmodule

// File: tb/tb_frame_tx_reader.sv
// tb_frame_tx_reader: directed bench for frame_tx_reader with a behavioural
// registered-read FIFO, a handshake monitor and hand-computed expectations.
module tb_frame_tx_reader;

`ifdef FRAME_TX_PAD_EN
  localparam int PAD_MIN = 60;
`else
  localparam int PAD_MIN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] len_in = 8'd0;
  logic       len_valid = 1'b0;
  logic [7:0] fifo_data = 8'd0;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       busy;
  logic       len_ovf;
  logic       underrun;

  frame_tx_reader dut (
    .clk(clk), .rst_n(rst_n), .len_in(len_in), .len_valid(len_valid),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy), .len_ovf(len_ovf), .underrun(underrun)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: registered read data one cycle after fifo_rd.
  logic [7:0] fmem [4096];
  int  fwr = 0;
  int  frd = 0;
  bit  force_empty = 1'b0;
  assign fifo_empty = force_empty || (fwr == frd);
  always @(posedge clk) begin
    if (fifo_rd && (fwr != frd)) begin
      fifo_data <= fmem[frd];
      frd       <= frd + 1;
    end
  end

  // tx_ready pattern: 0 = held high, 1 = toggling, 2 = held low.
  int ready_mode = 0;
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  // Monitor, sampled on the falling edge.
  int hs_cnt = 0, rd_cnt = 0, ovf_cnt = 0, und_cnt = 0, last_cnt = 0;
  int stall_viol = 0, gap_viol = 0, gap_left = 0, last_hs_cyc = 0, rise_cyc = 0;
  logic [7:0] cap_data [4096];
  int  cap_last [4096];
  int  cap_cyc [4096];
  bit  prev_stall = 1'b0, prev_valid = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'd0;
  always @(negedge clk) begin
    if (tx_valid && !prev_valid) rise_cyc = cyc;
    if (prev_stall && (!tx_valid || tx_data != prev_data || tx_last != prev_last))
      stall_viol++;
    if (gap_left > 0) begin
      if (tx_valid) gap_viol++;
      gap_left--;
    end
    if (tx_valid && tx_ready) begin
      cap_data[hs_cnt] = tx_data;
      cap_last[hs_cnt] = tx_last ? 1 : 0;
      cap_cyc[hs_cnt]  = cyc;
      hs_cnt++;
      if (tx_last) begin
        last_cnt++;
        last_hs_cyc = cyc;
        gap_left = 12;
      end
    end
    if (fifo_rd)  rd_cnt++;
    if (len_ovf)  ovf_cnt++;
    if (underrun) und_cnt++;
    prev_stall = tx_valid && !tx_ready && rst_n;
    prev_data  = tx_data;
    prev_last  = tx_last;
    prev_valid = tx_valid;
  end

  int errors = 0;
  int checks = 0;
  int exp_ptr = 0;
  int chk_idx = 0;

  task automatic check_eq(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int emit_len(input int len);
    return (len < PAD_MIN) ? PAD_MIN : len;
  endfunction

  task automatic preload(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) begin
      fmem[fwr] = 8'(base + i * step);
      fwr = fwr + 1;
    end
  endtask

  task automatic push_len(input int len);
    len_in    = 8'(len);
    len_valid = 1'b1;
    @(posedge clk);
    #1;
    len_valid = 1'b0;
  endtask

  task automatic wait_hs(input string tag, input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_done"}, (hs_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int at);
    int n = 0;
    while (busy && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    at = cyc;
    check_eq({tag, "_idle"}, busy ? 0 : 1, 1);
  endtask

  // Compares one captured frame against the bench's FIFO contents plus pad.
  task automatic check_frame(input string tag, input int len);
    int emit = emit_len(len);
    for (int i = 0; i < emit; i++) begin
      int expd = (i < len) ? int'(fmem[exp_ptr + i]) : 0;
      check_eq({tag, "_data"}, int'(cap_data[chk_idx + i]), expd);
      check_eq({tag, "_last"}, cap_last[chk_idx + i], (i == emit - 1) ? 1 : 0);
    end
    chk_idx = chk_idx + emit;
    exp_ptr = exp_ptr + len;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_fifo_rd"},  int'(fifo_rd), 0);
    check_eq({tag, "_tx_data"},  int'(tx_data), 0);
    check_eq({tag, "_tx_valid"}, int'(tx_valid), 0);
    check_eq({tag, "_tx_last"},  int'(tx_last), 0);
    check_eq({tag, "_busy"},     int'(busy), 0);
    check_eq({tag, "_len_ovf"},  int'(len_ovf), 0);
    check_eq({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, idle_at, hb, rb, lb, ob, ub, sb, gb, tot, lens [5], hs_at, rd_at, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // T1: 64-byte frame, tx_ready high
    preload(64, 0, 1);
    hb = hs_cnt; rb = rd_cnt; lb = last_cnt; gb = gap_viol; chk_idx = hb;
    c0 = cyc;
    push_len(64);
    wait_hs("t1", hb + 64, 300);
    wait_idle("t1", 100, idle_at);
    check_eq("t1_first_valid", rise_cyc - c0, 5);
    check_eq("t1_contig", cap_cyc[hb + 63] - cap_cyc[hb], 63);
    check_frame("t1", 64);
    check_eq("t1_hs", hs_cnt - hb, 64);
    check_eq("t1_rd", rd_cnt - rb, 64);
    check_eq("t1_lasts", last_cnt - lb, 1);
    check_eq("t1_gap", gap_viol - gb, 0);
    check_eq("t1_idle_at", idle_at - last_hs_cyc, 13);

    // T2: same frame, tx_ready toggling
    preload(64, 0, 1);
    ready_mode = 1;
    hb = hs_cnt; rb = rd_cnt; lb = last_cnt; sb = stall_viol; chk_idx = hb;
    push_len(64);
    wait_hs("t2", hb + 64, 400);
    wait_idle("t2", 100, idle_at);
    check_frame("t2", 64);
    check_eq("t2_hs", hs_cnt - hb, 64);
    check_eq("t2_rd", rd_cnt - rb, 64);
    check_eq("t2_lasts", last_cnt - lb, 1);
    check_eq("t2_stall", stall_viol - sb, 0);
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // T3: short frame, padded only when the pad feature is built in
    preload(10, 8'hA0, 1);
    hb = hs_cnt; rb = rd_cnt; chk_idx = hb;
    push_len(10);
    wait_hs("t3", hb + emit_len(10), 300);
    wait_idle("t3", 100, idle_at);
    check_frame("t3", 10);
    check_eq("t3_hs", hs_cnt - hb, emit_len(10));
    check_eq("t3_rd", rd_cnt - rb, 10);

    // T4: queue overflow while the first frame is stalled
    ready_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    preload(26, 8'h40, 1);
    hb = hs_cnt; rb = rd_cnt; lb = last_cnt; ob = ovf_cnt; chk_idx = hb;
    push_len(8);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("t4_stalled_valid", int'(tx_valid), 1);
    push_len(3); push_len(4); push_len(5); push_len(6); push_len(7);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t4_ovf", ovf_cnt - ob, 1);
    check_eq("t4_busy_held", int'(busy), 1);
    ready_mode = 0;
    lens[0] = 8; lens[1] = 3; lens[2] = 4; lens[3] = 5; lens[4] = 6;
    tot = 0;
    for (int i = 0; i < 5; i++) tot = tot + emit_len(lens[i]);
    for (int f = 0; f < 5; f++) begin
      wait_hs("t4_frame", hb + tot, 800);
    end
    wait_idle("t4", 100, idle_at);
    repeat (5) @(posedge clk);
    #1;
    check_eq("t4_no_extra", int'(busy), 0);
    for (int i = 0; i < 5; i++) check_frame("t4", lens[i]);
    check_eq("t4_hs", hs_cnt - hb, tot);
    check_eq("t4_rd", rd_cnt - rb, 26);
    check_eq("t4_lasts", last_cnt - lb, 5);

    // T5: FIFO starvation after the 20th read
    preload(64, 8'h80, 1);
    hb = hs_cnt; rb = rd_cnt; ub = und_cnt; chk_idx = hb;
    push_len(64);
    n = 0;
    while ((rd_cnt - rb) < 20 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("t5_reach20", rd_cnt - rb, 20);
    force_empty = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("t5_held_rd", rd_cnt - rb, 20);
    force_empty = 1'b0;
    wait_hs("t5", hb + 64, 300);
    wait_idle("t5", 100, idle_at);
    check_eq("t5_underrun", und_cnt - ub, 1);
    check_eq("t5_gap_after_19", (cap_cyc[hb + 20] - cap_cyc[hb + 19] > 1) ? 1 : 0, 1);
    check_frame("t5", 64);
    check_eq("t5_hs", hs_cnt - hb, 64);
    check_eq("t5_rd", rd_cnt - rb, 64);

    // T6: reset in the middle of a frame
    preload(64, 8'h11, 3);
    hb = hs_cnt; lb = last_cnt;
    push_len(64);
    wait_hs("t6", hb + 30, 200);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("t6_inrst");
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("t6_inrst_late");
    rst_n = 1'b1;
    hs_at = hs_cnt; rd_at = rd_cnt;
    repeat (30) @(posedge clk);
    #1;
    check_eq("t6_busy", int'(busy), 0);
    check_eq("t6_no_hs", hs_cnt - hs_at, 0);
    check_eq("t6_no_rd", rd_cnt - rd_at, 0);
    check_eq("t6_no_last", last_cnt - lb, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
